axis_serializer_credit_tx: RTL

AXIS_SERIALIZER_CREDIT_TX -- requirements
Module: axis_serializer_credit_tx

---
 rtl/noc_link_pkg.sv | 15 +
 rtl/noc_credit_counter.sv | 49 ++++
 rtl/axis_serializer_credit_tx.sv | 118 +++++++++++
 3 files changed

// File: rtl/noc_link_pkg.sv
// Shared NoC link definitions: link FSM states and the credit-counter width helper.
package noc_link_pkg;

  // The link holds either no beat (IDLE) or one beat being serialized (SEND).
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } link_state_e;

  // The count must be able to represent every value from 0 up to depth.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for a credit-based NoC link. It is shared by the transmit and receive shims.
// Ports: clk/rst (async active-high reset), consume (one flit sent),
//        credit_in (one credit returned), count (credits available),
//        overflow (sticky flag: a credit was returned while the counter was already full).
module noc_credit_counter
  import noc_link_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = credit_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             consume,
  input  logic             credit_in,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // A simultaneous send and return cancel out. A return while the counter is full sets the error flag.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (consume && !credit_in) begin
      if (count_q != '0) count_d = count_q - WIDTH'(1);
    end else if (credit_in && !consume) begin
      if (count_q == FULL) overflow_d = 1'b1;
      else                 count_d    = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= FULL;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/axis_serializer_credit_tx.sv
// Splits each AXI-Stream beat into SERIALIZATION_FACTOR flits (1, 2, 4 or 8).
// The least-significant slice is sent first. Flit sends are paced by credits from the downstream buffer.
// Ports: clk_noc/rst_noc (async active-high reset); axis_* slave beat input;
//        data_out/dest_out/is_tail_out/send_out flit output (send_out marks a valid flit);
//        credit_in returned credits; credit_count and credit_overflow give credit status.
module axis_serializer_credit_tx
  import noc_link_pkg::*;
#(
  parameter  int unsigned TDATA_WIDTH          = 128,
  parameter  int unsigned DEST_WIDTH           = 4,
  parameter  int unsigned SERIALIZATION_FACTOR = 4,
  parameter  int unsigned FLIT_BUFFER_DEPTH    = 8,
  localparam int unsigned FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int unsigned CREDIT_WIDTH         = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  input  logic [TDATA_WIDTH-1:0]  axis_tdata,
  input  logic                    axis_tlast,
  input  logic [DEST_WIDTH-1:0]   axis_tdest,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credit_overflow
);

  localparam int unsigned IDX_WIDTH = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);

  link_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d, idx_next;
  logic [TDATA_WIDTH-1:0] beat_q, beat_d;
  logic                   tlast_q, tlast_d;
  logic [DEST_WIDTH-1:0]  dest_q, dest_d;
  logic [FLIT_WIDTH-1:0]  data_out_q, data_out_d;
  logic [FLIT_WIDTH-1:0]  beat_slice [SERIALIZATION_FACTOR];

  logic is_last_idx_c, send_c, last_flit_fire_c, tready_c, accept_c;

  for (genvar g = 0; g < SERIALIZATION_FACTOR; g++) begin : g_slice
    assign beat_slice[g] = beat_q[g*FLIT_WIDTH +: FLIT_WIDTH];
  end

  // Handshake and flit-fire decode. Sends are blocked while the credit count is zero.
  always_comb begin
    is_last_idx_c    = (idx_q == LAST_IDX);
    send_c           = (state_q == SEND) && (credit_count != '0);
    last_flit_fire_c = send_c && is_last_idx_c;
    tready_c         = !rst_noc && ((state_q == IDLE) || last_flit_fire_c);
    accept_c         = axis_tvalid && tready_c;
    idx_next         = is_last_idx_c ? '0 : idx_q + IDX_WIDTH'(1);
  end

  // Next state. data_out_q is pre-loaded with the slice to send next,
  // so after the last flit it keeps showing that flit.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    tlast_d    = tlast_q;
    dest_d     = dest_q;
    data_out_d = data_out_q;
    if (accept_c) begin
      state_d    = SEND;
      idx_d      = '0;
      beat_d     = axis_tdata;
      tlast_d    = axis_tlast;
      dest_d     = axis_tdest;
      data_out_d = axis_tdata[FLIT_WIDTH-1:0];
    end else if (send_c) begin
      idx_d = idx_next;
      if (is_last_idx_c) state_d    = IDLE;
      else               data_out_d = beat_slice[idx_next];
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      beat_q     <= '0;
      tlast_q    <= 1'b0;
      dest_q     <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      tlast_q    <= tlast_d;
      dest_q     <= dest_d;
      data_out_q <= data_out_d;
    end
  end

  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH),
    .WIDTH (CREDIT_WIDTH)
  ) u_credit (
    .clk       (clk_noc),
    .rst       (rst_noc),
    .consume   (send_c),
    .credit_in (credit_in),
    .count     (credit_count),
    .overflow  (credit_overflow)
  );

  assign axis_tready = tready_c;
  assign send_out    = send_c;
  assign is_tail_out = last_flit_fire_c && tlast_q;
  assign data_out    = data_out_q;
  assign dest_out    = dest_q;

endmodule
